vector_list_writer: RTL
=======================

# vector_list_writer

Producer-side counterpart of the vector display's list reader: accepts point/draw commands over a valid/ready handshake, packs them into 18-bit vector words and writes them into one half of a double-buffered vector RAM while the display reads the other half. On frame completion it appends an end-of-frame word and waits for the display's frame-end pulse to swap banks. Sits between the frame-generation logic and the vector RAM that feeds `top_vector_display`.

## Interface
- `ADDRESSWIDTH`, 8, word address width per bank; bank depth 2^ADDRESSWIDTH
- `DATAWIDTH`, 18, vector word width; fixed layout {type[1:0], x[7:0], y[7:0]}
- `clk` in 1 system clock, all logic on rising edge
- `rst` in 1 reset; one clock; reset is asynchronous and active-high
- `in_valid` in 1 command valid
- `in_ready` out 1 writer can accept a command this cycle
- `in_x` in 8 X coordinate (DAC code)
- `in_y` in 8 Y coordinate (DAC code)
- `in_draw` in 1 1 = beam-on draw to point, 0 = beam-off move
- `frame_done` in 1 single-cycle pulse: close current frame
- `disp_frame_end` in 1 single-cycle pulse from display: finished a pass over its bank
- `wr_en` out 1 RAM write strobe
- `wr_bank` out 1 bank being written
- `wr_addr` out ADDRESSWIDTH RAM word address within `wr_bank`
- `wr_data` out DATAWIDTH RAM write data
- `disp_bank` out 1 bank the display must read; always `~wr_bank`
- `overflow` out 1 sticky: commands dropped in current frame

## Operation
- Word types: 2'b00 MOVE, 2'b01 DRAW, 2'b10 END (x=y=0), 2'b11 unused, never written.
- States: FILL, TERM, WAIT_SWAP. Reset → FILL.
- FILL: `in_ready`=1. Accepted command (`in_valid && in_ready`) → write {in_draw?DRAW:MOVE, in_x, in_y} at current pointer; pointer +1. `frame_done` → TERM.
- `frame_done` and accepted command in same cycle: command written first, END follows next cycle.
- Capacity: vector slots 0..2^AW−2; slot 2^AW−1 reserved for END. Command accepted when pointer = 2^AW−1: dropped (no write), `overflow` set, `in_ready` stays 1 (no stall).
- TERM: `in_ready`=0; write END at pointer (pointer ≤ 2^AW−1 guaranteed); → WAIT_SWAP.
- WAIT_SWAP: `in_ready`=0, no writes. On `disp_frame_end`: toggle `wr_bank`, pointer ← 0, `overflow` ← 0, → FILL.
- `disp_frame_end` in FILL or TERM: ignored (display redraws old bank).
- `frame_done` outside FILL: ignored.
- Empty frame (`frame_done` with pointer 0): END at slot 0.

## Timing
- Reset values: `in_ready`=0 while `rst` high, 1 from first cycle after release; `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_bank`=0, `disp_bank`=1, `overflow`=0, pointer 0.
- `wr_en`/`wr_addr`/`wr_data` registered: command accepted at edge N appears at edge N+1, held one cycle.
- END write: `wr_en` high the cycle after entering TERM; WAIT_SWAP entered same edge.
- Bank swap: `wr_bank`/`disp_bank` toggle on the edge sampling `disp_frame_end`; first new-frame command accepted earliest next cycle.
- `overflow` rises the cycle after the dropped command's handshake.
- Reset mid-frame: all state to reset values immediately; partial bank content undefined, display reads bank 1.
- Throughput: one command per cycle in FILL.

## Configuration
- `VECTOR_WRITER_DEDUP_EN` defined: in FILL, a command whose {type,x,y} equals the last word written in this frame is dropped (handshake completes, no write, pointer unchanged, `overflow` unaffected); last-word register cleared on swap and reset.
- Undefined: every accepted command is written, duplicates included.

## Test plan
- Reset, send MOVE(0x10,0x20), DRAW(0x80,0x90), `frame_done` → writes bank0 addr0=0x01020, addr1=0x18090, addr2=0x20000; `in_ready`=0 afterward.
- In WAIT_SWAP pulse `disp_frame_end` → `wr_bank`=1, `disp_bank`=0, next command written at addr0 of bank1.
- ADDRESSWIDTH=4: 20 DRAWs then `frame_done` → 15 writes (addr 0..14), `overflow`=1 after 16th handshake, END at addr15; cleared on swap.
- `in_valid` and `frame_done` same cycle → command at addr N, END at addr N+1 next cycle.
- `disp_frame_end` during FILL → no swap, writes continue; assert `rst` mid-frame → outputs return to reset values asynchronously.
- With `VECTOR_WRITER_DEDUP_EN`: DRAW(5,5) twice then DRAW(6,6) → addr0=DRAW(5,5), addr1=DRAW(6,6); without macro → three writes.

Source files
------------

// File: rtl/vector_list_writer.sv
// vector_list_writer: packs point/draw commands into {type,x,y} vector words and
// writes them into one half of a double-buffered vector RAM. On frame close it
// appends an END word, then waits for the display's frame-end pulse to swap banks.
// Optional build macro: VECTOR_WRITER_DEDUP_EN drops a command identical to the
// last word written in the current frame.
module vector_list_writer #(
   parameter int ADDRESSWIDTH = 8,
   parameter int DATAWIDTH    = 18
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_x,
   input  logic [7:0]              in_y,
   input  logic                    in_draw,
   input  logic                    frame_done,
   input  logic                    disp_frame_end,
   output logic                    wr_en,
   output logic                    wr_bank,
   output logic [ADDRESSWIDTH-1:0] wr_addr,
   output logic [DATAWIDTH-1:0]    wr_data,
   output logic                    disp_bank,
   output logic                    overflow
);

   typedef enum logic [1:0] {FILL, TERM, WAIT_SWAP} state_t;

   localparam logic [1:0] TYPE_MOVE = 2'b00;
   localparam logic [1:0] TYPE_DRAW = 2'b01;
   localparam logic [1:0] TYPE_END  = 2'b10;
   // Last slot of a bank is kept free so the END word always fits.
   localparam logic [ADDRESSWIDTH-1:0] PTR_LAST = '1;

   state_t                  state_q, state_d;
   logic [ADDRESSWIDTH-1:0] ptr_q, ptr_d;
   logic                    wr_bank_q, wr_bank_d;
   logic                    overflow_q, overflow_d;
   logic                    in_ready_q, in_ready_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDRESSWIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATAWIDTH-1:0]    wr_data_q, wr_data_d;

   logic [DATAWIDTH-1:0]    cmd_word;
   logic [DATAWIDTH-1:0]    end_word;
   logic                    accept;
   logic                    is_dup;

   assign cmd_word = DATAWIDTH'({(in_draw ? TYPE_DRAW : TYPE_MOVE), in_x, in_y});
   assign end_word = DATAWIDTH'({TYPE_END, 16'h0000});
   // in_ready_q is only ever high in FILL; the state term keeps the intent explicit.
   assign accept   = in_valid && in_ready_q && (state_q == FILL);

`ifdef VECTOR_WRITER_DEDUP_EN
   logic [DATAWIDTH-1:0] last_q, last_d;
   logic                 last_valid_q, last_valid_d;

   assign is_dup = last_valid_q && (cmd_word == last_q);

   // Last-word register used to suppress repeated identical commands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q       <= '0;
         last_valid_q <= 1'b0;
      end else begin
         last_q       <= last_d;
         last_valid_q <= last_valid_d;
      end
   end
`else
   assign is_dup = 1'b0;
`endif

   // Next-state and next-output computation for the fill / terminate / swap sequence.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      wr_bank_d  = wr_bank_q;
      overflow_d = overflow_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
`ifdef VECTOR_WRITER_DEDUP_EN
      last_d       = last_q;
      last_valid_d = last_valid_q;
`endif
      case (state_q)
         FILL: begin
            if (accept && !is_dup) begin
               if (ptr_q == PTR_LAST) begin
                  // Bank full: drop silently without stalling the producer.
                  overflow_d = 1'b1;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = cmd_word;
                  ptr_d     = ptr_q + ADDRESSWIDTH'(1);
`ifdef VECTOR_WRITER_DEDUP_EN
                  last_d       = cmd_word;
                  last_valid_d = 1'b1;
`endif
               end
            end
            // A command in the same cycle is written first; END follows at ptr+1.
            if (frame_done) begin
               state_d = TERM;
            end
         end
         TERM: begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = end_word;
            state_d   = WAIT_SWAP;
         end
         WAIT_SWAP: begin
            if (disp_frame_end) begin
               wr_bank_d  = ~wr_bank_q;
               ptr_d      = '0;
               overflow_d = 1'b0;
               state_d    = FILL;
`ifdef VECTOR_WRITER_DEDUP_EN
               last_d       = '0;
               last_valid_d = 1'b0;
`endif
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
      in_ready_d = (state_d == FILL);
   end

   // State register with registered outputs; reset returns to an empty frame in bank 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FILL;
         ptr_q      <= '0;
         wr_bank_q  <= 1'b0;
         overflow_q <= 1'b0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         wr_bank_q  <= wr_bank_d;
         overflow_q <= overflow_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign wr_en     = wr_en_q;
   assign wr_bank   = wr_bank_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign disp_bank = ~wr_bank_q;
   assign overflow  = overflow_q;

endmodule
